// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: the decoder control bundle and the ALU-op encodings.
package riscv_pipe_pkg;

  localparam int unsigned CTRL_W = 8;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // Decoder control bundle carried down the pipe, MSB first.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard compare: the load in EX writes a register that ID reads.
// Ports:
//   id_valid_i      ID holds a real instruction
//   ex_valid_i      EX holds a real instruction
//   ex_mem_read_i   EX instruction is a load
//   ex_rd_i         EX destination index
//   id_rs1_i/rs2_i  ID source indices
//   hazard_c_o      combinational hazard flag
module id_ex_hazard #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              id_valid_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              hazard_c_o
);

  logic rd_nonzero_c;
  logic src_match_c;

  // x0 is never written, so a load into x0 can never create a dependency.
  assign rd_nonzero_c = (ex_rd_i != REG_AW'(0));
  assign src_match_c  = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
  assign hazard_c_o   = id_valid_i && ex_valid_i && ex_mem_read_i && rd_nonzero_c && src_match_c;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection.
// Captures the decoder control bundle and ID operands each cycle, inserts one
// bubble per load-use hazard, and clears its contents on a mispredict flush.
// Ports:
//   clk_i, rst_i                 clock (rising), async active-high reset
//   id_*_i                       ID-stage control, operands and indices
//   flush_i                      kill the instruction entering EX
//   hold_i                       freeze all EX registers
//   noop_o                       to decoder: force control to zero (comb)
//   stall_o                      to PC / IF-ID: hold fetch and decode (comb)
//   ex_*_o                       registered EX-stage copies
// Optional: define ID_EX_PERF_EN to add saturating bubble_cnt_o / flush_cnt_o.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  ctrl_t             id_ctrl_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [9:0]        id_funct_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              noop_o,
  output logic              stall_o,
  output ctrl_t             ex_ctrl_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [9:0]        ex_funct_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  ctrl_t              ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic [REG_AW-1:0]  rs1_q, rs1_d;
  logic [REG_AW-1:0]  rs2_q, rs2_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic [9:0]         funct_q, funct_d;
  logic               hazard_c;
  logic               bubble_c;

  id_ex_hazard #(.REG_AW(REG_AW)) u_hazard (
    .id_valid_i    (id_valid_i),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (rd_q),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .hazard_c_o    (hazard_c)
  );

  // A flush already empties EX, so it absorbs the hazard without stalling.
  assign noop_o   = !rst_i && hazard_c && !flush_i;
  assign stall_o  = !rst_i && (noop_o || hold_i);
  // A bubble is only counted as inserted when neither flush nor hold wins.
  assign bubble_c = hazard_c && !flush_i && !hold_i;

  // Next-state priority: flush > hold > hazard bubble > capture.
  always_comb begin
    ctrl_d     = ctrl_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    funct_d    = funct_q;
    if (flush_i || (!hold_i && hazard_c)) begin
      ctrl_d     = '0;
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      funct_d    = '0;
    end else if (!hold_i) begin
      ctrl_d     = id_valid_i ? id_ctrl_i : '0;
      valid_d    = id_valid_i;
      pc_d       = id_pc_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      imm_d      = id_imm_i;
      rs1_d      = id_rs1_i;
      rs2_d      = id_rs2_i;
      rd_d       = id_rd_i;
      funct_d    = id_funct_i;
    end
  end

  // EX register bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct_q    <= funct_d;
    end
  end

  assign ex_ctrl_o     = ctrl_q;
  assign ex_valid_o    = valid_q;
  assign ex_pc_o       = pc_q;
  assign ex_rs1_data_o = rs1_data_q;
  assign ex_rs2_data_o = rs2_data_q;
  assign ex_imm_o      = imm_q;
  assign ex_rs1_o      = rs1_q;
  assign ex_rs2_o      = rs2_q;
  assign ex_rd_o       = rd_q;
  assign ex_funct_o    = funct_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bubble_c && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF))   flush_cnt_d  = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`else
  logic unused_c;
  assign unused_c = bubble_c;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import riscv_pipe_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [7:0] C_LW  = 8'h2B;
  localparam logic [7:0] C_ADD = 8'h82;
  localparam logic [7:0] C_SW  = 8'h24;

  logic              clk = 1'b0;
  logic              rst_i;
  ctrl_t             id_ctrl_i;
  logic              id_valid_i;
  logic [XLEN-1:0]   id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [9:0]        id_funct_i;
  logic              flush_i, hold_i;
  logic              noop_o, stall_o;
  ctrl_t             ex_ctrl_o;
  logic              ex_valid_o;
  logic [XLEN-1:0]   ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [REG_AW-1:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [9:0]        ex_funct_o;
`ifdef ID_EX_PERF_EN
  logic [31:0]       bubble_cnt_o, flush_cnt_o;
`endif

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_ctrl_i     (id_ctrl_i),
    .id_valid_i    (id_valid_i),
    .id_pc_i       (id_pc_i),
    .id_rs1_data_i (id_rs1_data_i),
    .id_rs2_data_i (id_rs2_data_i),
    .id_imm_i      (id_imm_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_funct_i    (id_funct_i),
    .flush_i       (flush_i),
    .hold_i        (hold_i),
    .noop_o        (noop_o),
    .stall_o       (stall_o),
    .ex_ctrl_o     (ex_ctrl_o),
    .ex_valid_o    (ex_valid_o),
    .ex_pc_o       (ex_pc_o),
    .ex_rs1_data_o (ex_rs1_data_o),
    .ex_rs2_data_o (ex_rs2_data_o),
    .ex_imm_o      (ex_imm_o),
    .ex_rs1_o      (ex_rs1_o),
    .ex_rs2_o      (ex_rs2_o),
    .ex_rd_o       (ex_rd_o),
    .ex_funct_o    (ex_funct_o)
`ifdef ID_EX_PERF_EN
    ,
    .bubble_cnt_o  (bubble_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive an instruction into ID; data operands are derived from the PC.
  task automatic drive_id(input logic v, input logic [7:0] c, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc);
    id_valid_i    = v;
    id_ctrl_i     = c;
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_rd_i       = rd;
    id_pc_i       = pc;
    id_rs1_data_i = pc + 32'h100;
    id_rs2_data_i = pc + 32'h200;
    id_imm_i      = pc + 32'h4;
    id_funct_i    = pc[9:0];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    hold_i  = 1'b0;
    drive_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0);
    tick; tick;

    // 1. Reset: R-type captured, then async reset mid-cycle
    rst_i = 1'b0;
    drive_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 32'h1000);
    tick;
    check("add_capture_ctrl", 32'(ex_ctrl_o), 32'(C_ADD));
    check("add_capture_pc", ex_pc_o, 32'h1000);
    check("add_capture_imm", ex_imm_o, 32'h1004);
    hold_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    check("rst_ctrl", 32'(ex_ctrl_o), 32'h0);
    check("rst_valid", 32'(ex_valid_o), 32'h0);
    check("rst_pc", ex_pc_o, 32'h0);
    check("rst_rs1_data", ex_rs1_data_o, 32'h0);
    check("rst_rd", 32'(ex_rd_o), 32'h0);
    check("rst_noop", 32'(noop_o), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    tick;
    rst_i  = 1'b0;
    hold_i = 1'b0;
    drive_id(1'b0, C_ADD, 5'd5, 5'd5, 5'd0, 32'h1010);
    tick;
    check("invalid_id_ctrl_zero", 32'(ex_ctrl_o), 32'h0);
    check("invalid_id_valid", 32'(ex_valid_o), 32'h0);

    // 2. lw x5 then add x6,x5,x1
    drive_id(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 32'h2000);
    tick;
    check("lw_in_ex_ctrl", 32'(ex_ctrl_o), 32'(C_LW));
    drive_id(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 32'h2004);
    #1;
    check("lu_noop", 32'(noop_o), 32'h1);
    check("lu_stall", 32'(stall_o), 32'h1);
    tick;
    check("bubble_ctrl", 32'(ex_ctrl_o), 32'h0);
    check("bubble_valid", 32'(ex_valid_o), 32'h0);
    check("bubble_pc", ex_pc_o, 32'h0);
    check("bubble_noop_clear", 32'(noop_o), 32'h0);
    check("bubble_stall_clear", 32'(stall_o), 32'h0);
    tick;
    check("add_after_bubble_ctrl", 32'(ex_ctrl_o), 32'(C_ADD));
    check("add_after_bubble_rd", 32'(ex_rd_o), 32'd6);
    check("add_after_bubble_rs1data", ex_rs1_data_o, 32'h2104);

    // 3. lw x0 then reader of x0: no stall
    drive_id(1'b1, C_LW, 5'd2, 5'd0, 5'd0, 32'h3000);
    tick;
    drive_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd7, 32'h3004);
    #1;
    check("x0_no_noop", 32'(noop_o), 32'h0);
    tick;
    check("x0_add_enters", 32'(ex_valid_o), 32'h1);
    // sw x5 behind lw x5: rs2 match
    drive_id(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 32'h3100);
    tick;
    drive_id(1'b1, C_SW, 5'd2, 5'd5, 5'd0, 32'h3104);
    #1;
    check("sw_rs2_noop", 32'(noop_o), 32'h1);
    tick;
    check("sw_bubble_valid", 32'(ex_valid_o), 32'h0);
    tick;
    check("sw_enters_ctrl", 32'(ex_ctrl_o), 32'(C_SW));

    // 4. Hazard together with flush
    drive_id(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 32'h4000);
    tick;
    drive_id(1'b1, C_ADD, 5'd5, 5'd1, 5'd6, 32'h4004);
    flush_i = 1'b1;
    #1;
    check("flush_noop", 32'(noop_o), 32'h0);
    check("flush_stall", 32'(stall_o), 32'h0);
    tick;
    flush_i = 1'b0;
    check("flush_valid", 32'(ex_valid_o), 32'h0);
    check("flush_ctrl", 32'(ex_ctrl_o), 32'h0);
    check("flush_pc", ex_pc_o, 32'h0);
    tick;
    check("after_flush_add_enters", 32'(ex_ctrl_o), 32'(C_ADD));

    // 5. Hold for 3 cycles with a dependent instruction waiting
    drive_id(1'b1, C_LW, 5'd2, 5'd0, 5'd5, 32'h5000);
    tick;
    drive_id(1'b1, C_ADD, 5'd1, 5'd5, 5'd6, 32'h5004);
    hold_i = 1'b1;
    #1;
    check("hold_stall", 32'(stall_o), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("hold_ctrl_stable", 32'(ex_ctrl_o), 32'(C_LW));
      check("hold_pc_stable", ex_pc_o, 32'h5000);
      check("hold_stall_high", 32'(stall_o), 32'h1);
    end
    hold_i = 1'b0;
    #1;
    check("release_noop", 32'(noop_o), 32'h1);
    tick;
    check("release_bubble_valid", 32'(ex_valid_o), 32'h0);
    check("release_bubble_ctrl", 32'(ex_ctrl_o), 32'h0);
    tick;
    check("release_add_enters", ex_pc_o, 32'h5004);

`ifdef ID_EX_PERF_EN
    // 6. Three bubbles inserted (steps 2, 3, 5), one flush applied
    check("perf_bubble_cnt", bubble_cnt_o, 32'd3);
    check("perf_flush_cnt", flush_cnt_o, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
